// File: rtl/clm_mul_sched_pkg.sv
// Shared types for the masked CLM multiplier and the schedulers that front it.
package clm_mul_sched_pkg;

  typedef logic [7:0] red_poly_t;
  typedef logic [4:0] p_det_t;

  localparam int unsigned MASK_D = 2;

  // One randomness draw for a single masked multiplication (9+D elements).
  typedef red_poly_t [0:8+MASK_D] rnd_vec_t;

  typedef enum logic [2:0] {
    IDLE,
    RND,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/clm_mul_sched_if.sv
// Scheduler-to-multiplier connection: operands, selector, randomness and start/done strobes.
interface clm_mul_sched_if
  import clm_mul_sched_pkg::*;
#(
  parameter int unsigned D = 2
);

  logic                  mul_drdy_i;
  logic [15:0]           mul_p1;
  logic [15:0]           mul_p2;
  p_det_t                mul_pdet;
  red_poly_t [0:8+D]     mul_rnd;
  logic                  mul_drdy_o;
  logic [15:0]           mul_out;

  modport master (
    output mul_drdy_i, mul_p1, mul_p2, mul_pdet, mul_rnd,
    input  mul_drdy_o, mul_out
  );

  modport slave (
    input  mul_drdy_i, mul_p1, mul_p2, mul_pdet, mul_rnd,
    output mul_drdy_o, mul_out
  );

endinterface

// File: rtl/clm_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/clm_mul_sched.sv
// Shares one masked CLM multiplier among NREQ requesters, one operation at a time,
// with a fresh randomness vector per operation and a WAIT-state timeout.
module clm_mul_sched
  import clm_mul_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned D       = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0][15:0]  req_p1,
  input  logic [NREQ-1:0][15:0]  req_p2,
  input  p_det_t [NREQ-1:0]      req_pdet,
  output logic [NREQ-1:0]        resp_valid,
  output logic [15:0]            resp_out,
  output logic                   resp_err,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  red_poly_t [0:8+D]      rnd_i,
  clm_mul_sched_if.master        mul,
  output logic                   busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  sched_state_t    state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   arb_idx;
  logic [NREQ-1:0] arb_grant;
  logic [CW-1:0]   cnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Acceptance strobes qualify the same-cycle valid; gated so reset never acknowledges.
  assign req_ready = (state == IDLE && !rst) ? arb_grant : '0;
  assign rnd_ready = (state == RND) && rnd_valid && !rst;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      gnt_idx        <= '0;
      cnt            <= '0;
      mul.mul_drdy_i <= 1'b0;
      mul.mul_p1     <= '0;
      mul.mul_p2     <= '0;
      mul.mul_pdet   <= '0;
      mul.mul_rnd    <= '0;
      resp_valid     <= '0;
      resp_out       <= '0;
      resp_err       <= 1'b0;
    end else begin
      mul.mul_drdy_i <= 1'b0;
      resp_valid     <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            mul.mul_p1   <= req_p1[arb_idx];
            mul.mul_p2   <= req_p2[arb_idx];
            mul.mul_pdet <= req_pdet[arb_idx];
            gnt_idx      <= arb_idx;
            rr_ptr       <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
            state        <= RND;
          end
        end
        RND: begin
          // Start strobe is registered here so it is high for the whole ISSUE cycle.
          if (rnd_valid) begin
            mul.mul_rnd    <= rnd_i;
            mul.mul_drdy_i <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mul.mul_drdy_o) begin
            resp_out   <= mul.mul_out;
            resp_err   <= 1'b0;
            resp_valid <= NREQ'(1) << gnt_idx;
            state      <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            resp_out   <= '0;
            resp_err   <= 1'b1;
            resp_valid <= NREQ'(1) << gnt_idx;
            state      <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/clm_mul_sched.md
Name: clm_mul_sched

Overview:
- Round-robin scheduler that shares one masked CLM multiplier among NREQ requesters.
- Per operation it latches the winner's operands and p_det, and draws a fresh randomness vector from an external source.
- It issues a single-cycle drdy_i to the multiplier, waits for drdy_o and routes the result back to the winner.
- p_det and the randomness vector are held stable for the whole operation, because the parameter extractor and the multiplier consume them combinationally.

Parameters:
- NREQ, 4, number of requesters (2..8).
- D, 2, masking order; the randomness vector holds 9+D red_poly_t elements.
- TIMEOUT, 255, maximum cycles in WAIT before the operation is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  NREQ  request pending, per requester.
- req_ready  out  NREQ  one-hot; high for one cycle when that requester's operands are accepted.
- req_p1, req_p2  in  NREQx16  operands per requester.
- req_pdet  in  NREQx5  field/parameter selector per requester.
- resp_valid  out  NREQ  one-hot single-cycle result strobe.
- resp_out  out  16  result, valid with resp_valid.
- resp_err  out  1  with resp_valid: the operation timed out and resp_out is 0.
- rnd_valid  in  1  randomness source has a vector.
- rnd_ready  out  1  vector consumed this cycle.
- rnd_i  in  (9+D)x8  fresh randomness, red_poly_t elements.
- mul_drdy_i  out  1  start strobe to the multiplier.
- mul_p1, mul_p2  out  16  operands to the multiplier.
- mul_pdet  out  5  to p_param_extractor.
- mul_rnd  out  (9+D)x8  to multiplier random_vect.
- mul_drdy_o  in  1  multiplier done, single-cycle pulse.
- mul_out  in  16  multiplier result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0. Reset asserted in any state aborts the operation: no resp_valid is produced and no rnd_ready is raised.
- IDLE: if any req_valid is set, grant the first requester at or after rr_ptr, wrapping modulo NREQ. In the same cycle:
  - pulse req_ready[g];
  - latch p1, p2 and pdet into mul_p1, mul_p2 and mul_pdet;
  - store g;
  - set rr_ptr to (g+1) mod NREQ;
  - go to RND.
- Requests that are not granted keep waiting. A requester may deassert req_valid at any time before it is granted.
- RND: wait for rnd_valid. On rnd_valid, pulse rnd_ready, latch rnd_i into mul_rnd, go to ISSUE. Randomness is never reused across operations; the scheduler stalls indefinitely while rnd_valid is low.
- ISSUE: mul_drdy_i = 1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On mul_drdy_o, latch mul_out into resp_out, set resp_err to 0, go to RESP.
  - If the counter reaches TIMEOUT first, set resp_out to 0 and resp_err to 1, go to RESP.
  - If mul_drdy_o arrives in the same cycle the counter reaches TIMEOUT, mul_drdy_o wins and the result is good.
- RESP: resp_valid[g] = 1 for one cycle; go to IDLE.
- Latency: with rnd_valid already high and a multiplier latency of L cycles from drdy_i to drdy_o, the grant-to-resp_valid latency is L+3 cycles.
- Back-to-back operations: a new grant happens at the earliest in the cycle after RESP.
- Stability: mul_p1, mul_p2, mul_pdet and mul_rnd stay constant from their latch until the next grant. They are never modified during WAIT.
- mul_drdy_o pulses outside WAIT (stale or spurious) are ignored.
- A timeout leaves the multiplier state undefined. The next operation is still issued normally; the multiplier is expected to restart on drdy_i.

Decomposition:
- Add to types, the shared package already holding red_poly_t and p_det_t:
  - sched_state_t enum {IDLE, RND, ISSUE, WAIT, RESP};
  - the rnd_vec_t alias red_poly_t [0:8+D].
- One sub-module, rr_arbiter. Inputs: req[NREQ] and ptr. Outputs: one-hot grant and the grant index. It is combinational and reused by other shared-resource schedulers.
- The counter and FSM stay in clm_mul_sched.

Test Plan:
- Single request: req0 with p1=16'h123f, p2=16'h123f, pdet=13; rnd always valid; the multiplier model returns 16'hBEEF after L=4 -> req_ready[0] at cycle 0, mul_drdy_i at cycle 2, resp_valid[0] with 16'hBEEF at cycle 7, mul_pdet=13 held throughout.
- Fairness: all 4 req_valid held high for 8 operations -> grant order 0,1,2,3,0,1,2,3, each resp_valid routed to the matching index.
- Randomness stall: rnd_valid low for 10 cycles after the grant -> no mul_drdy_i until 1 cycle after rnd_valid rises; mul_rnd equals the vector presented on that edge (all 8'd34).
- Timeout: the model never asserts drdy_o, TIMEOUT=255 -> resp_valid with resp_err=1 and resp_out=0 about 257 cycles after the grant; the next request completes correctly.
- Reset mid-WAIT: assert rst for 1 cycle -> busy=0, all outputs 0, no resp_valid; a late mul_drdy_o is ignored.
- Spurious drdy_o in IDLE -> no resp_valid, state unchanged.
